// File: rtl/counter_arbiter_pkg.sv
// Types and helpers shared by the counter arbiter and its bench.
package counter_arbiter_pkg;
  `include "counter_arbiter_defs.vh"

  localparam int CW_DEFAULT = `CA_DEFAULT_CW;

  typedef enum logic {
    ST_IDLE = `CA_ST_IDLE,
    ST_RUN  = `CA_ST_RUN
  } state_e;

  // Two-requester round-robin: the favoured one wins a tie, a lone requester always wins.
  function automatic logic rr_pick(input logic [1:0] r, input logic fav);
    if (r[0] && r[1]) return fav;
    return r[1];
  endfunction
endpackage

// File: rtl/counter_arbiter_defs.vh
// Shared encodings for the counter arbiter: FSM state values and default counter width.
`ifndef COUNTER_ARBITER_DEFS_VH
`define COUNTER_ARBITER_DEFS_VH
`define CA_ST_IDLE    1'b0
`define CA_ST_RUN     1'b1
`define CA_DEFAULT_CW 4
`endif

// File: rtl/down_counter.sv
// Loadable down-counter that saturates at zero; load wins over enable.
module down_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] din,
  output logic [CW-1:0] q
);
  logic [CW-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)                  q_d = din;
    else if (en && q_q != '0)  q_d = q_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter; each grant lasts len+1 cycles, timed by a shared down-counter.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int CW   = CW_DEFAULT,
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [CW-1:0]      cnt
);
  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            ld, en, pick;
  logic [CW-1:0]   din;

  assign pick = rr_pick(req[1:0], ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    ld      = 1'b0;
    en      = 1'b0;
    din     = '0;
    done    = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req[1:0]) begin
          win_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          ptr_d       = ~pick;
          ld          = 1'b1;
          din         = pick ? len[CW +: CW] : len[0 +: CW];
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!req[win_q] || cnt == '0) begin
          // Abort and normal completion both drop the grant and clear the counter;
          // only completion with the request still held reports done.
          if (req[win_q]) done = gnt_q;
          gnt_d   = '0;
          ld      = 1'b1;
          state_d = ST_IDLE;
        end else begin
          en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
    end
  end

  down_counter #(.CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .en   (en),
    .din  (din),
    .q    (cnt)
  );

  assign gnt  = gnt_q;
  assign busy = (state_q == ST_RUN);
endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: single grant, contention, zero length, abort, async reset, len change.
module tb_counter_arbiter;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req = '0;
  logic [2*CW-1:0] len = '0;
  logic [1:0]    gnt, done;
  logic          busy;
  logic [CW-1:0] cnt;

  int tests = 0;
  int fails = 0;

  counter_arbiter #(.CW(CW), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len),
    .gnt(gnt), .done(done), .busy(busy), .cnt(cnt)
  );

  always #5 clk = ~clk;

  // Edge, then settle; observed value packs {gnt, done, busy, cnt}.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; len = '0;
    tick(); tick();
    tests++;
    if ({gnt, done, busy, cnt} !== 9'b0) begin
      fails++;
      $display("FAIL reset: got %b want %b", {gnt, done, busy, cnt}, 9'b0);
    end
    rst = 1'b1;
    tick();
    tests++;
    if ({gnt, done, busy, cnt} !== 9'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got %b want %b", {gnt, done, busy, cnt}, 9'b0);
    end
  endtask

  task automatic test_single();
    logic [8:0] exp;
    req = 2'b01; len = {4'd0, 4'd3};
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {2'b01, (i == 3) ? 2'b01 : 2'b00, 1'b1, 4'(3 - i)};
      tests++;
      if ({gnt, done, busy, cnt} !== exp) begin
        fails++;
        $display("FAIL single cyc%0d: got %b want %b", i, {gnt, done, busy, cnt}, exp);
      end
    end
    tick();
    tests++;
    if ({gnt, done, busy, cnt} !== 9'b0) begin
      fails++;
      $display("FAIL single idle: got %b want %b", {gnt, done, busy, cnt}, 9'b0);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] eg [8] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [1:0] ed [8] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    logic [3:0] ec [8] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd2};
    logic [8:0] exp;
    // Previous grant left the pointer on requester 1; reset must restore it to 0.
    rst = 1'b0; #1; rst = 1'b1;
    req = 2'b11; len = {4'd1, 4'd2};
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = {eg[i], ed[i], (eg[i] != 2'b00), ec[i]};
      tests++;
      if ({gnt, done, busy, cnt} !== exp) begin
        fails++;
        $display("FAIL contention cyc%0d: got %b want %b", i, {gnt, done, busy, cnt}, exp);
      end
    end
    req = 2'b00;
    tick();
    tests++;
    if ({gnt, done, busy, cnt} !== 9'b0) begin
      fails++;
      $display("FAIL contention drop: got %b want %b", {gnt, done, busy, cnt}, 9'b0);
    end
  endtask

  task automatic test_zero_len();
    req = 2'b10; len = {4'd0, 4'd7};
    tick();
    tests++;
    if ({gnt, done, busy, cnt} !== {2'b10, 2'b10, 1'b1, 4'd0}) begin
      fails++;
      $display("FAIL zero_len grant: got %b want %b", {gnt, done, busy, cnt}, {2'b10, 2'b10, 1'b1, 4'd0});
    end
    req = 2'b00;
    tick();
    tests++;
    if ({gnt, done, busy, cnt} !== 9'b0) begin
      fails++;
      $display("FAIL zero_len end: got %b want %b", {gnt, done, busy, cnt}, 9'b0);
    end
  endtask

  task automatic test_abort();
    logic [8:0] exp;
    req = 2'b01; len = {4'd0, 4'd15};
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = {2'b01, 2'b00, 1'b1, 4'(15 - i)};
      tests++;
      if ({gnt, done, busy, cnt} !== exp) begin
        fails++;
        $display("FAIL abort run%0d: got %b want %b", i, {gnt, done, busy, cnt}, exp);
      end
    end
    req = 2'b00;
    #1;
    tests++;
    if (done !== 2'b00) begin
      fails++;
      $display("FAIL abort done_comb: got %b want %b", done, 2'b00);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if ({gnt, done, busy, cnt} !== 9'b0) begin
        fails++;
        $display("FAIL abort idle%0d: got %b want %b", i, {gnt, done, busy, cnt}, 9'b0);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    req = 2'b10; len = {4'd5, 4'd1};
    tick();
    tests++;
    if ({gnt, busy, cnt} !== {2'b10, 1'b1, 4'd5}) begin
      fails++;
      $display("FAIL rstmid pre: got %b want %b", {gnt, busy, cnt}, {2'b10, 1'b1, 4'd5});
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if ({gnt, done, busy, cnt} !== 9'b0) begin
      fails++;
      $display("FAIL rstmid async: got %b want %b", {gnt, done, busy, cnt}, 9'b0);
    end
    rst = 1'b1;
    req = 2'b11;
    tick();
    tests++;
    if ({gnt, done, busy, cnt} !== {2'b01, 2'b00, 1'b1, 4'd1}) begin
      fails++;
      $display("FAIL rstmid rr: got %b want %b", {gnt, done, busy, cnt}, {2'b01, 2'b00, 1'b1, 4'd1});
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_len_change();
    logic [8:0] exp;
    req = 2'b01; len = {4'd0, 4'd4};
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = {2'b01, (i == 4) ? 2'b01 : 2'b00, 1'b1, 4'(4 - i)};
      tests++;
      if ({gnt, done, busy, cnt} !== exp) begin
        fails++;
        $display("FAIL len_change cyc%0d: got %b want %b", i, {gnt, done, busy, cnt}, exp);
      end
      // Late len change and a competing request must not disturb the active grant.
      len = {4'd3, 4'd9};
      req = 2'b11;
    end
    tick();
    tests++;
    if ({gnt, done, busy, cnt} !== 9'b0) begin
      fails++;
      $display("FAIL len_change idle: got %b want %b", {gnt, done, busy, cnt}, 9'b0);
    end
    req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero_len();
    test_abort();
    test_reset_mid_run();
    test_len_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter CW, default 4: width of the shared counter and of each length field.
REQ-002 Parameter NREQ, default 2: number of requesters; only the value 2 is supported.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester request, level-sensitive.
REQ-006 len  input  NREQ*CW  requested count per requester; requester i uses bits [i*CW +: CW].
REQ-007 gnt  output  NREQ  one-hot grant; all zero when idle.
REQ-008 done  output  NREQ  one-cycle completion flag for the granted requester.
REQ-009 busy  output  1  high while any grant is active.
REQ-010 cnt  output  CW  current value of the shared down-counter.

Function
REQ-011 The FSM shall have two states: IDLE and RUN.
REQ-012 In IDLE with no req bit set, the block shall hold cnt, gnt, done and busy at 0.
REQ-013 In IDLE with any req bit set, the block shall select a winner w by round-robin, then at the next edge:
  - set gnt[w] and busy;
  - load cnt with len[w];
  - enter RUN.
REQ-014 Round-robin rule: a pointer names the favoured requester.
  - If both request, the favoured one wins.
  - If one requests, it wins regardless of the pointer.
  - After any grant, the pointer moves to the other requester.
REQ-015 In RUN with cnt != 0 and req[w] high, cnt shall decrement by 1 per cycle.
REQ-016 In RUN with cnt == 0 and req[w] high, done[w] shall be 1 in that same cycle.
  - At the next edge: gnt, busy and cnt go to 0, and the FSM enters IDLE.
REQ-017 Grant duration shall be exactly len[w]+1 cycles; len = 0 gives a one-cycle grant with done asserted.
REQ-018 len shall be sampled only at the IDLE->RUN load; later changes to len shall have no effect on the active grant.
REQ-019 Abort: if req[w] goes low in RUN, the next edge shall clear gnt, busy and cnt and enter IDLE with no done pulse.
  - The pointer still moves to the other requester.
REQ-020 A request from the non-granted requester during RUN shall be ignored until IDLE.
REQ-021 At least one IDLE cycle shall separate consecutive grants.
REQ-022 If req[w] is still high in the IDLE cycle after done, it shall be arbitrated as a new request.
REQ-023 done and gnt shall never be asserted for different requesters.
REQ-024 gnt shall never have more than one bit set.
REQ-025 cnt shall never wrap below 0.

Reset
REQ-026 On rst low, the block shall asynchronously force:
  - state = IDLE;
  - gnt, done, busy and cnt = 0;
  - pointer = requester 0.
REQ-027 Reset asserted mid-RUN shall abort the grant immediately, with no done pulse.
REQ-028 After rst rises, the first arbitration shall occur on the first edge at which a req bit is high.

Structure
REQ-029 A shared include file counter_arbiter_defs.vh shall hold:
  - the state encodings (IDLE = 0, RUN = 1);
  - the default CW.
REQ-030 The counter datapath shall be a sub-module down_counter (clk, rst, load, en, din[CW], q[CW]).
  - load has priority over en.
  - When q = 0, the decrement shall saturate at 0.
REQ-031 Arbitration, the pointer and the FSM shall live in counter_arbiter; there shall be no other sub-modules.

Verification
REQ-032 Single request: req = 01, len0 = 3 -> gnt = 01 for 4 cycles; cnt = 3,2,1,0; done = 01 on the cnt = 0 cycle; then IDLE.
REQ-033 Contention: req = 11 held, len0 = 2, len1 = 1 after reset ->
  - grant 0 for 3 cycles;
  - one IDLE cycle;
  - grant 1 for 2 cycles;
  - one IDLE cycle;
  - grant 0 again.
REQ-034 Zero length: req = 10, len1 = 0 -> gnt = 10 and done = 10 for exactly one cycle, cnt = 0 throughout.
REQ-035 Abort: req = 01, len0 = 15; drop req0 when cnt = 10 -> next edge gnt = 00, cnt = 0, no done pulse ever.
REQ-036 Reset mid-run: grant 1 active with cnt = 5; pulse rst low between edges ->
  - outputs 0 immediately, without waiting for a clock edge;
  - after release, with req = 11, requester 0 wins.
REQ-037 Len change: len0 changed from 4 to 9 during RUN -> grant still lasts 5 cycles.
